// File: rtl/sram_arb_if.sv
// Two-requester SRAM access bundle: requester handshakes, read-data returns
// and the SRAM strobes. The arbiter uses the slave modport.
interface sram_arb_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) ();
  logic              req0;
  logic              req1;
  logic              we0;
  logic              we1;
  logic [ADDR_W-1:0] addr0;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata0;
  logic [DATA_W-1:0] wdata1;
  logic              gnt0;
  logic              gnt1;
  logic              rvalid0;
  logic              rvalid1;
  logic [DATA_W-1:0] rdata0;
  logic [DATA_W-1:0] rdata1;
  logic              mem_cs;
  logic              mem_we;
  logic              mem_re;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_cs, mem_we, mem_re, mem_addr, mem_wdata
  );

  modport master (
    output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
    input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1,
           mem_cs, mem_we, mem_re, mem_addr, mem_wdata
  );
endinterface

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single-port SRAM; one transaction at a time.
// Define SRAM_ARB_RR_EN for round-robin on contention, otherwise port 0 wins.
module sram_arbiter #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  sram_arb_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, RWAIT, RDONE} state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              cs_q, cs_d;
  logic              mwe_q, mwe_d;
  logic              mre_q, mre_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              rv0_q, rv0_d;
  logic              rv1_q, rv1_d;
  logic [DATA_W-1:0] rdata0_q, rdata0_d;
  logic [DATA_W-1:0] rdata1_q, rdata1_d;
  logic              pick;

`ifdef SRAM_ARB_RR_EN
  // High means port 1 is favoured on the next contention.
  logic              ptr_q, ptr_d;

  always_ff @(posedge clk) begin
    if (rst) ptr_q <= 1'b0;
    else     ptr_q <= ptr_d;
  end
`endif

  // Next-state and registered-output computation.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cs_d     = 1'b0;
    mwe_d    = 1'b0;
    mre_d    = 1'b0;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    rv0_d    = 1'b0;
    rv1_d    = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
`ifdef SRAM_ARB_RR_EN
    ptr_d    = ptr_q;
    pick     = bus.req1 & (~bus.req0 | ptr_q);
`else
    pick     = bus.req1 & ~bus.req0;
`endif

    case (state_q)
      IDLE: begin
        if (bus.req0 | bus.req1) begin
          state_d = ACCESS;
          owner_d = pick;
          we_d    = pick ? bus.we1    : bus.we0;
          addr_d  = pick ? bus.addr1  : bus.addr0;
          wdata_d = pick ? bus.wdata1 : bus.wdata0;
          cs_d    = 1'b1;
          mwe_d   = we_d;
          mre_d   = ~we_d;
          gnt0_d  = ~pick;
          gnt1_d  = pick;
`ifdef SRAM_ARB_RR_EN
          ptr_d   = ~pick;
`endif
        end
      end
      ACCESS: state_d = we_q ? IDLE : RWAIT;
      RWAIT: begin
        // SRAM data is valid during this cycle; capture it for the owner only.
        state_d = RDONE;
        if (owner_q) begin
          rdata1_d = bus.mem_rdata;
          rv1_d    = 1'b1;
        end else begin
          rdata0_d = bus.mem_rdata;
          rv0_d    = 1'b1;
        end
      end
      RDONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cs_q     <= 1'b0;
      mwe_q    <= 1'b0;
      mre_q    <= 1'b0;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      rv0_q    <= 1'b0;
      rv1_q    <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cs_q     <= cs_d;
      mwe_q    <= mwe_d;
      mre_q    <= mre_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      rv0_q    <= rv0_d;
      rv1_q    <= rv1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign bus.gnt0      = gnt0_q;
  assign bus.gnt1      = gnt1_q;
  assign bus.rvalid0   = rv0_q;
  assign bus.rvalid1   = rv1_q;
  assign bus.rdata0    = rdata0_q;
  assign bus.rdata1    = rdata1_q;
  assign bus.mem_cs    = cs_q;
  assign bus.mem_we    = mwe_q;
  assign bus.mem_re    = mre_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter: directed scenarios plus a randomized
// run against a transaction-level timing model with a behavioural SRAM.
module tb_sram_arbiter;
  localparam int unsigned ADDR_W      = 4;
  localparam int unsigned DATA_W      = 8;
  localparam int unsigned DEPTH       = 16;
  localparam int          RAND_CYCLES = 600;

  // Strobe vector layout: {gnt0, gnt1, rvalid0, rvalid1, mem_cs, mem_we, mem_re}
  localparam logic [6:0] S_G0 = 7'b1000000;
  localparam logic [6:0] S_G1 = 7'b0100000;
  localparam logic [6:0] S_R0 = 7'b0010000;
  localparam logic [6:0] S_R1 = 7'b0001000;
  localparam logic [6:0] S_CS = 7'b0000100;
  localparam logic [6:0] S_WE = 7'b0000010;
  localparam logic [6:0] S_RE = 7'b0000001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   cs_adj = 0;
  logic prev_cs = 1'b0;
  logic preload = 1'b0;
  logic [DATA_W-1:0] preload_mem [DEPTH];
  logic [DATA_W-1:0] sram        [DEPTH];
  logic [DATA_W-1:0] model_mem   [DEPTH];

  always #5 clk = ~clk;

  sram_arb_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Behavioural SRAM: read data valid only in the cycle after a read strobe.
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < DEPTH; i++) sram[i] <= preload_mem[i];
    end else if (bus.mem_cs === 1'b1 && bus.mem_we === 1'b1) begin
      sram[bus.mem_addr] <= bus.mem_wdata;
    end
    if (bus.mem_cs === 1'b1 && bus.mem_re === 1'b1) bus.mem_rdata <= sram[bus.mem_addr];
    else                                            bus.mem_rdata <= DATA_W'($urandom);
  end

  function automatic logic [6:0] strb();
    return {bus.gnt0, bus.gnt1, bus.rvalid0, bus.rvalid1, bus.mem_cs, bus.mem_we, bus.mem_re};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (prev_cs === 1'b1 && bus.mem_cs === 1'b1) cs_adj++;
    prev_cs = bus.mem_cs;
  endtask

  task automatic drive(input int p, input logic r, input logic w,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (p == 0) begin
      bus.req0 = r; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
    end else begin
      bus.req1 = r; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < DEPTH; i++) begin
      preload_mem[i] = DATA_W'(32'h5A ^ i);
      model_mem[i]   = DATA_W'(32'h5A ^ i);
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    rst = 1'b1;
    preload = 1'b1;
    tick();
    preload = 1'b0;
    tick();
    checks++;
    if (strb() !== 7'b0) begin
      errors++; $display("FAIL reset_strobes: got %b expected %b", strb(), 7'b0);
    end
    checks++;
    if ({bus.mem_addr, bus.mem_wdata, bus.rdata0, bus.rdata1} !== '0) begin
      errors++; $display("FAIL reset_data: got %h %h %h %h expected all zero",
                         bus.mem_addr, bus.mem_wdata, bus.rdata0, bus.rdata1);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_write();
    drive(0, 1'b1, 1'b1, 4'h3, 8'hA5);
    tick();
    checks++;
    if (strb() !== (S_G0 | S_CS | S_WE)) begin
      errors++; $display("FAIL write_strobes: got %b expected %b", strb(), S_G0 | S_CS | S_WE);
    end
    checks++;
    if ({bus.mem_addr, bus.mem_wdata} !== {4'h3, 8'hA5}) begin
      errors++; $display("FAIL write_fields: got %h/%h expected 3/a5", bus.mem_addr, bus.mem_wdata);
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    tick();
    checks++;
    if (strb() !== 7'b0) begin
      errors++; $display("FAIL write_idle: got %b expected %b", strb(), 7'b0);
    end
  endtask

  task automatic test_read_back();
    drive(1, 1'b1, 1'b0, 4'h3, '0);
    tick();
    checks++;
    if (strb() !== (S_G1 | S_CS | S_RE) || bus.mem_addr !== 4'h3) begin
      errors++; $display("FAIL readback_access: got %b addr %h expected %b addr 3",
                         strb(), bus.mem_addr, S_G1 | S_CS | S_RE);
    end
    drive(1, 1'b0, 1'b0, '0, '0);
    tick();
    checks++;
    if (strb() !== 7'b0) begin
      errors++; $display("FAIL readback_rwait: got %b expected %b", strb(), 7'b0);
    end
    tick();
    checks++;
    if (strb() !== S_R1 || bus.rdata1 !== 8'hA5) begin
      errors++; $display("FAIL readback_data: got %b data %h expected %b data a5",
                         strb(), bus.rdata1, S_R1);
    end
    checks++;
    if (bus.rdata0 !== 8'h00) begin
      errors++; $display("FAIL readback_other_port: got %h expected 00", bus.rdata0);
    end
    tick();
    checks++;
    if (strb() !== 7'b0 || bus.rdata1 !== 8'hA5) begin
      errors++; $display("FAIL readback_hold: got %b data %h expected 0 data a5", strb(), bus.rdata1);
    end
  endtask

  task automatic test_contention();
    int n0 = 0;
    int n1 = 0;
    int exp_p;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(0, 1'b1, 1'b1, ADDR_W'(8 + n0),  DATA_W'(8'hC0 + n0));
    drive(1, 1'b1, 1'b1, ADDR_W'(12 + n1), DATA_W'(8'hD0 + n1));
    for (int k = 0; k < 4; k++) begin
      tick();
`ifdef SRAM_ARB_RR_EN
      exp_p = k % 2;
`else
      exp_p = 0;
`endif
      checks++;
      if (strb() !== (((exp_p == 1) ? S_G1 : S_G0) | S_CS | S_WE)) begin
        errors++; $display("FAIL contention_grant%0d: got %b expected port %0d", k, strb(), exp_p);
      end
      checks++;
      if (exp_p == 1 ? ({bus.mem_addr, bus.mem_wdata} !== {ADDR_W'(12 + n1), DATA_W'(8'hD0 + n1)})
                     : ({bus.mem_addr, bus.mem_wdata} !== {ADDR_W'(8 + n0), DATA_W'(8'hC0 + n0)})) begin
        errors++; $display("FAIL contention_fields%0d: got %h/%h for port %0d",
                           k, bus.mem_addr, bus.mem_wdata, exp_p);
      end
      if (exp_p == 1) begin
        n1++;
        drive(1, 1'b1, 1'b1, ADDR_W'(12 + n1), DATA_W'(8'hD0 + n1));
      end else begin
        n0++;
        drive(0, 1'b1, 1'b1, ADDR_W'(8 + n0), DATA_W'(8'hC0 + n0));
      end
      tick();
      checks++;
      if (strb() !== 7'b0) begin
        errors++; $display("FAIL contention_gap%0d: got %b expected %b", k, strb(), 7'b0);
      end
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic test_reset_rwait();
    drive(0, 1'b1, 1'b0, 4'h3, '0);
    tick();
    checks++;
    if (strb() !== (S_G0 | S_CS | S_RE)) begin
      errors++; $display("FAIL rstrw_access: got %b expected %b", strb(), S_G0 | S_CS | S_RE);
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (strb() !== 7'b0 ||
        {bus.mem_addr, bus.mem_wdata, bus.rdata0, bus.rdata1} !== '0) begin
      errors++; $display("FAIL rstrw_outputs: got %b %h %h %h %h expected all zero", strb(),
                         bus.mem_addr, bus.mem_wdata, bus.rdata0, bus.rdata1);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (strb() !== 7'b0 || bus.rdata0 !== 8'h00) begin
      errors++; $display("FAIL rstrw_no_rvalid: got %b data %h expected 0 data 00", strb(), bus.rdata0);
    end
    drive(0, 1'b1, 1'b0, 4'h3, '0);
    tick();
    checks++;
    if (strb() !== (S_G0 | S_CS | S_RE)) begin
      errors++; $display("FAIL rstrw_resume: got %b expected %b", strb(), S_G0 | S_CS | S_RE);
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    tick();
    tick();
    checks++;
    if (strb() !== S_R0 || bus.rdata0 !== 8'hA5) begin
      errors++; $display("FAIL rstrw_data: got %b data %h expected %b data a5", strb(), bus.rdata0, S_R0);
    end
  endtask

  task automatic test_boundary();
    tick();
    cs_adj = 0;
    drive(0, 1'b1, 1'b1, 4'hF, 8'hFF);
    tick();
    checks++;
    if (strb() !== (S_G0 | S_CS | S_WE) || {bus.mem_addr, bus.mem_wdata} !== {4'hF, 8'hFF}) begin
      errors++; $display("FAIL bound_write: got %b %h/%h expected %b f/ff",
                         strb(), bus.mem_addr, bus.mem_wdata, S_G0 | S_CS | S_WE);
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    tick();
    drive(1, 1'b1, 1'b0, 4'h0, '0);
    tick();
    checks++;
    if (strb() !== (S_G1 | S_CS | S_RE) || bus.mem_addr !== 4'h0) begin
      errors++; $display("FAIL bound_read0_access: got %b addr %h", strb(), bus.mem_addr);
    end
    drive(1, 1'b0, 1'b0, '0, '0);
    tick();
    tick();
    checks++;
    if (strb() !== S_R1 || bus.rdata1 !== model_mem[0]) begin
      errors++; $display("FAIL bound_read0_data: got %b data %h expected %b data %h",
                         strb(), bus.rdata1, S_R1, model_mem[0]);
    end
    // Raised during RDONE: must wait for the following idle cycle.
    drive(0, 1'b1, 1'b0, 4'hF, '0);
    tick();
    checks++;
    if (strb() !== 7'b0) begin
      errors++; $display("FAIL bound_no_early_grant: got %b expected %b", strb(), 7'b0);
    end
    tick();
    checks++;
    if (strb() !== (S_G0 | S_CS | S_RE) || bus.mem_addr !== 4'hF) begin
      errors++; $display("FAIL bound_readf_access: got %b addr %h", strb(), bus.mem_addr);
    end
    drive(0, 1'b0, 1'b0, '0, '0);
    tick();
    tick();
    checks++;
    if (strb() !== S_R0 || bus.rdata0 !== 8'hFF || bus.rdata1 !== model_mem[0]) begin
      errors++; $display("FAIL bound_readf_data: got %b data %h/%h expected %b data ff/%h",
                         strb(), bus.rdata0, bus.rdata1, S_R0, model_mem[0]);
    end
    checks++;
    if (cs_adj !== 0) begin
      errors++; $display("FAIL bound_cs_adjacent: got %0d expected 0", cs_adj);
    end
  endtask

  task automatic test_random();
    logic              act   [2];
    logic              rwe   [2];
    logic [ADDR_W-1:0] raddr [2];
    logic [DATA_W-1:0] rwd   [2];
    logic [6:0]        exp_strb [8];
    logic [ADDR_W-1:0] exp_addr [8];
    logic [DATA_W-1:0] exp_wd   [8];
    logic [DATA_W-1:0] exp_rdv  [8];
    logic [DATA_W-1:0] exp_rd0, exp_rd1;
    int free_at, s, n, m, w;
`ifdef SRAM_ARB_RR_EN
    int last_w = 1;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      preload_mem[i] = DATA_W'($urandom);
      model_mem[i]   = preload_mem[i];
    end
    for (int i = 0; i < 8; i++) begin
      exp_strb[i] = '0; exp_addr[i] = '0; exp_wd[i] = '0; exp_rdv[i] = '0;
    end
    for (int p = 0; p < 2; p++) begin
      act[p] = 1'b0; rwe[p] = 1'b0; raddr[p] = '0; rwd[p] = '0;
      drive(p, 1'b0, 1'b0, '0, '0);
    end
    exp_rd0 = '0;
    exp_rd1 = '0;
    free_at = 0;
    rst = 1'b1;
    preload = 1'b1;
    tick();
    rst = 1'b0;
    preload = 1'b0;
    cs_adj = 0;
    for (int cyc = 0; cyc < RAND_CYCLES; cyc++) begin
      s = cyc % 8;
      if ((exp_strb[s] & S_R0) != 0) exp_rd0 = exp_rdv[s];
      if ((exp_strb[s] & S_R1) != 0) exp_rd1 = exp_rdv[s];
      checks++;
      if (strb() !== exp_strb[s]) begin
        errors++; $display("FAIL rand_strobes cyc %0d: got %b expected %b", cyc, strb(), exp_strb[s]);
      end
      if ((exp_strb[s] & S_CS) != 0) begin
        checks++;
        if (bus.mem_addr !== exp_addr[s] ||
            ((exp_strb[s] & S_WE) != 0 && bus.mem_wdata !== exp_wd[s])) begin
          errors++; $display("FAIL rand_fields cyc %0d: got %h/%h expected %h/%h",
                             cyc, bus.mem_addr, bus.mem_wdata, exp_addr[s], exp_wd[s]);
        end
      end
      checks++;
      if ({bus.rdata0, bus.rdata1} !== {exp_rd0, exp_rd1}) begin
        errors++; $display("FAIL rand_rdata cyc %0d: got %h/%h expected %h/%h",
                           cyc, bus.rdata0, bus.rdata1, exp_rd0, exp_rd1);
      end
      exp_strb[s] = '0;

      for (int p = 0; p < 2; p++) begin
        if (!act[p] && $urandom_range(0, 3) == 0) begin
          act[p]   = 1'b1;
          rwe[p]   = 1'($urandom_range(0, 1));
          raddr[p] = ADDR_W'($urandom);
          rwd[p]   = DATA_W'($urandom);
        end
        drive(p, act[p], rwe[p], raddr[p], rwd[p]);
      end

      // Transaction-level model: one access at a time; write busy 2 cycles, read 4.
      if (cyc >= free_at && (act[0] || act[1])) begin
`ifdef SRAM_ARB_RR_EN
        w = (act[0] && act[1]) ? ((last_w == 0) ? 1 : 0) : (act[1] ? 1 : 0);
        last_w = w;
`else
        w = act[0] ? 0 : 1;
`endif
        act[w] = 1'b0;
        n = (cyc + 1) % 8;
        exp_strb[n] = exp_strb[n] | ((w == 1) ? S_G1 : S_G0) | S_CS | (rwe[w] ? S_WE : S_RE);
        exp_addr[n] = raddr[w];
        exp_wd[n]   = rwd[w];
        if (rwe[w]) begin
          model_mem[raddr[w]] = rwd[w];
          free_at = cyc + 2;
        end else begin
          m = (cyc + 3) % 8;
          exp_strb[m] = exp_strb[m] | ((w == 1) ? S_R1 : S_R0);
          exp_rdv[m]  = model_mem[raddr[w]];
          free_at = cyc + 4;
        end
      end
      tick();
    end
    for (int p = 0; p < 2; p++) drive(p, 1'b0, 1'b0, '0, '0);
    checks++;
    if (cs_adj !== 0) begin
      errors++; $display("FAIL rand_cs_adjacent: got %0d expected 0", cs_adj);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_single_write();
    test_read_back();
    test_contention();
    test_reset_rwait();
    test_boundary();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
